// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-side responder for the cache line-fill port.
// It holds a line-organised backing store and serves whole-line reads and
// writes. Each access completes a fixed LATENCY cycles after it is accepted,
// and completion is signalled by a one-cycle `ready` pulse.
// LATENCY must be in 1..15. MEM_LINES must be a power of two.
// Optional build macro LINE_MEM_STATS_EN adds the rd_count/wr_count
// completion counters. Core behaviour is the same with or without it.
module line_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int LINE_WORDS = 4,
    parameter int MEM_LINES  = 256
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       readM,
    input  logic                       writeM,
    input  logic [15:0]                address,
    inout  wire  [LINE_WORDS*16-1:0]   data,
    output logic                       ready,
    output logic                       busy
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [15:0]                rd_count,
    output logic [15:0]                wr_count
`endif
);

    localparam int LINE_W = LINE_WORDS * 16;
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic                op_wr_q;      // 1 = write, 0 = read
    logic                ready_q;
    logic                busy_q;
    logic                drive_q;      // bus enable, only during a read RESP
    logic [LINE_W-1:0]   rd_data_q;
    logic [LINE_W-1:0]   mem_q [MEM_LINES];

    // Values sampled from the request this cycle
    logic                req_d;
    logic [IDX_W-1:0]    idx_d;
    logic                op_wr_d;
    logic                same_d;
    logic                commit_d;
    logic                mem_we;
    logic                mem_re;

    // Only the line-index bits of the address matter. The rest are
    // deliberately dropped so the address space wraps.
    logic unused_addr_lo;
    assign unused_addr_lo = ^address[1:0];

    generate
        if (IDX_W + 2 <= 15) begin : g_addr_hi_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[15:IDX_W+2];
        end
    endgenerate

    // Decode the incoming request and detect the commit edge
    always_comb begin
        req_d    = readM | writeM;
        idx_d    = address[IDX_W+1:2];
        op_wr_d  = writeM;              // writeM wins when both are high
        same_d   = (idx_d == idx_q) && (op_wr_d == op_wr_q);
        commit_d = (state_q == BUSY) && req_d && same_d && (cnt_q == 4'd1);
        mem_we   = commit_d && op_wr_q && reset_n;
        mem_re   = commit_d && !op_wr_q;
    end

    // Transaction FSM with registered ready/busy/bus-enable outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_wr_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            drive_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        idx_q   <= idx_d;
                        op_wr_q <= op_wr_d;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req_d) begin
                        // Initiator withdrew: drop the access silently
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!same_d) begin
                        // A new line or operation restarts the full latency
                        idx_q   <= idx_d;
                        op_wr_q <= op_wr_d;
                        cnt_q   <= CNT_LOAD;
                    end else if (cnt_q == 4'd1) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        drive_q <= !op_wr_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Line store write port. There is no reset, so the array maps onto block RAM.
    // The commit edge is itself a BUSY edge, so the bus sample on that edge is the
    // freshest write data. It is written straight in.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= data;
        end
    end

    // Registered read of the line store, loaded on the edge that enters RESP
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (mem_re) begin
            rd_data_q <= mem_q[idx_q];
        end
    end

`ifdef LINE_MEM_STATS_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    // Count completed accesses on the edge that leaves RESP
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (state_q == RESP) begin
            if (op_wr_q) begin
                wr_count_q <= wr_count_q + 16'd1;
            end else begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

    assign ready = ready_q;
    assign busy  = busy_q;
    assign data  = drive_q ? rd_data_q : {LINE_W{1'bz}};

endmodule

// File: tb/tb_line_mem_responder.sv
// Testbench for line_mem_responder. Stimulus tasks push the expected
// response (cycle, kind, line value) into a queue. An independent monitor
// pops one entry on every ready pulse and compares it against the DUT.
`timescale 1ns/1ps
module tb_line_mem_responder;

    localparam int LAT = 4;
    localparam int LW  = 4;
    localparam int ML  = 256;
    localparam int DW  = LW * 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          readM = 1'b0;
    logic          writeM = 1'b0;
    logic [15:0]   address = '0;
    wire  [DW-1:0] data;
    logic          tb_drv = 1'b0;
    logic [DW-1:0] tb_wdata = '0;
    logic          ready;
    logic          busy;
`ifdef LINE_MEM_STATS_EN
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;
`endif

    assign data = tb_drv ? tb_wdata : {DW{1'bz}};

    line_mem_responder #(
        .LATENCY    (LAT),
        .LINE_WORDS (LW),
        .MEM_LINES  (ML)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .readM    (readM),
        .writeM   (writeM),
        .address  (address),
        .data     (data),
        .ready    (ready),
        .busy     (busy)
`ifdef LINE_MEM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          rd;
        int            idx;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [ML];
    int            checks = 0;
    int            errors = 0;
    int            rd_done = 0;
    int            wr_done = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int line_of(input logic [15:0] a);
        return (int'(a) >> 2) % ML;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation
    exp_t mon_e;
    always @(negedge clk) begin
        if (ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ready=1 at cycle %0d, required no response", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_cycle", DW'(cyc), DW'(mon_e.cyc));
                check("resp_data", data, mon_e.val);
                check("busy_at_ready", DW'(busy), DW'(1));
                if (mon_e.rd) rd_done++;
                else          wr_done++;
                $display("txn %s line %0d data=%h cycle %0d", mon_e.rd ? "RD" : "WR",
                         mon_e.idx, data, cyc);
            end
        end
    end

    // Wait (bounded) for the ready pulse, then release the request after RESP
    task automatic wait_ready_and_drop();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > 4 * LAT + 10) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: no ready after %0d cycles, required a response", n);
                break;
            end
        end
        @(posedge clk); #1;
        readM  = 1'b0;
        writeM = 1'b0;
        tb_drv = 1'b0;
`ifdef LINE_MEM_STATS_EN
        check("rd_count", DW'(rd_count), DW'(rd_done[15:0]));
        check("wr_count", DW'(wr_count), DW'(wr_done[15:0]));
`endif
    endtask

    // One complete transaction; called just after a rising edge
    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [DW-1:0] wd);
        exp_t e;
        readM    = rd;
        writeM   = wr;
        address  = a;
        tb_drv   = wr;
        tb_wdata = wd;
        e.cyc = cyc + 1 + LAT;
        e.rd  = !wr;
        e.idx = line_of(a);
        if (wr) begin
            model[e.idx] = wd;
            e.val = wd;
        end else begin
            e.val = model[e.idx];
        end
        exp_q.push_back(e);
        wait_ready_and_drop();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", DW'(busy), DW'(0));
        check("reset_ready", DW'(ready), DW'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);
        check("idle_busy", DW'(busy), DW'(0));

        // Fill the store so every line has known contents
        for (int i = 0; i < ML; i++) begin
            do_txn(1'b0, 1'b1, 16'(i << 2), {$urandom, $urandom});
        end

        // Write then read within one line
        do_txn(1'b0, 1'b1, 16'h0010, 64'h1111_2222_3333_4444);
        do_txn(1'b1, 1'b0, 16'h0013, 64'h0);
        check("model_rw", model[line_of(16'h0013)], 64'h1111_2222_3333_4444);

        // Address wrap: 0x0400 aliases line 0
        do_txn(1'b0, 1'b1, 16'h0400, 64'hAAAA_0000_0000_5555);
        do_txn(1'b1, 1'b0, 16'h0000, 64'h0);

        // Both requests high: a write
        do_txn(1'b1, 1'b1, 16'h0020, 64'hDEAD_BEEF_CAFE_F00D);
        idle(1);
        do_txn(1'b1, 1'b0, 16'h0020, 64'h0);

        // Abort: writeM withdrawn after two cycles
        readM = 1'b0; writeM = 1'b1; address = 16'h0030;
        tb_drv = 1'b1; tb_wdata = 64'h1;
        idle(1);
        check("abort_busy_high", DW'(busy), DW'(1));
        idle(1);
        writeM = 1'b0; tb_drv = 1'b0;
        idle(1);
        check("abort_busy_low", DW'(busy), DW'(0));
        idle(LAT + 3);
`ifdef LINE_MEM_STATS_EN
        check("abort_wr_count", DW'(wr_count), DW'(wr_done[15:0]));
`endif
        do_txn(1'b1, 1'b0, 16'h0030, 64'h0);

        // Line change mid-BUSY restarts the latency
        readM = 1'b1; writeM = 1'b0; address = 16'h0040;
        idle(3);
        address = 16'h0044;
        e.cyc = cyc + 1 + LAT;
        e.rd  = 1'b1;
        e.idx = line_of(16'h0044);
        e.val = model[e.idx];
        exp_q.push_back(e);
        wait_ready_and_drop();

        // Reset one cycle before a write would commit
        readM = 1'b0; writeM = 1'b1; address = 16'h0050;
        tb_drv = 1'b1; tb_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
        idle(3);
        reset_n = 1'b0;
        writeM = 1'b0; tb_drv = 1'b0;
        rd_done = 0; wr_done = 0;
        idle(1);
        check("rst_mid_busy", DW'(busy), DW'(0));
        check("rst_mid_ready", DW'(ready), DW'(0));
        idle(2);
        reset_n = 1'b1;
        idle(LAT + 3);
        check("rst_after_busy", DW'(busy), DW'(0));
        do_txn(1'b1, 1'b0, 16'h0050, 64'h0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int op;
            op = $urandom_range(0, 2);
            do_txn(op != 1, op != 0, 16'($urandom), {$urandom, $urandom});
            idle($urandom_range(0, 2));
        end

        idle(LAT + 3);
        check("pending_responses", DW'(exp_q.size()), DW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
